// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer beside ID/EX: owns CP0 Status/Cause/EPC and
// runs the drain -> flush -> redirect sequence to the handler or back to EPC.
//
// state    | meaning
// IDLE     | evaluate events from EX, accept mtc0 writes
// DRAIN    | stall until MEM finishes its outstanding access
// FLUSH    | one-cycle flush of IF/ID, ID/EX, EX/MEM
// REDIRECT | present redirect_pc until the PC register acks
module exc_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0800,
  parameter int          IRQ_W        = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [31:0]      ex_pc,
  input  logic             syscall,
  input  logic             eret,
  input  logic             overflow,
  input  logic [IRQ_W-1:0] int_req,
  input  logic             mem_busy,
  input  logic             cp0_we,
  input  logic [4:0]       cp0_addr,
  input  logic [31:0]      cp0_wdata,
  output logic [31:0]      cp0_rdata,
  output logic             stall,
  output logic             flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  input  logic             redirect_ack,
  output logic             in_handler
);

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, REDIRECT} state_t;

  state_t           state, state_nx;
  logic             ie, exl;
  logic [IRQ_W-1:0] im;
  logic [4:0]       exccode;
  logic [31:0]      epc, target;

  logic             irq_hit, take_exc, take_eret;
  logic [4:0]       code_nx;

  always_comb begin
    irq_hit   = ie & ~exl & (|(int_req & im));
    take_exc  = (state == IDLE) & ex_valid & (overflow | syscall | irq_hit);
    // eret is lowest priority; an interrupt can never coexist with it since it needs EXL=0
    take_eret = (state == IDLE) & ex_valid & ~overflow & ~syscall & eret & exl;
    if (overflow)     code_nx = 5'd12;
    else if (syscall) code_nx = 5'd8;
    else              code_nx = 5'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (take_exc || take_eret) state_nx = mem_busy ? DRAIN : FLUSH;
      DRAIN:    if (!mem_busy) state_nx = FLUSH;
      FLUSH:    state_nx = REDIRECT;
      REDIRECT: if (redirect_ack) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    stall          = (state == DRAIN) || (state == FLUSH);
    flush          = (state == FLUSH);
    redirect_valid = (state == REDIRECT);
    redirect_pc    = target;
    in_handler     = exl;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ie      <= 1'b0;
      exl     <= 1'b0;
      im      <= '0;
      exccode <= 5'd0;
      epc     <= 32'd0;
      target  <= 32'd0;
    end else if (take_exc) begin
      exccode <= code_nx;
      if (!exl) epc <= ex_pc;
      exl     <= 1'b1;
      ie      <= 1'b0;
      target  <= HANDLER_ADDR;
    end else if (take_eret) begin
      exl     <= 1'b0;
      ie      <= 1'b1;
      target  <= epc;
    end else if (state == IDLE && cp0_we) begin
      case (cp0_addr)
        5'd12: begin
          ie  <= cp0_wdata[0];
          exl <= cp0_wdata[1];
          im  <= cp0_wdata[10 +: IRQ_W];
        end
        5'd13:   exccode <= cp0_wdata[6:2];
        5'd14:   epc     <= cp0_wdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_addr)
      5'd12: begin
        cp0_rdata[0]            = ie;
        cp0_rdata[1]            = exl;
        cp0_rdata[10 +: IRQ_W]  = im;
      end
      5'd13: begin
        cp0_rdata[6:2]          = exccode;
        cp0_rdata[10 +: IRQ_W]  = int_req;
      end
      5'd14:   cp0_rdata = epc;
      default: cp0_rdata = 32'd0;
    endcase
  end

endmodule
